// File: rtl/spi_sample_master_if.sv
// Host-side word interface of spi_sample_master.
//   tx_valid/tx_ready/tx_data : word to send, accepted on tx_valid && tx_ready
//   rx_valid/rx_data          : one-cycle pulse with the word just received
//   busy                      : frame or inter-frame gap in progress
// The master modport is the host side and the slave modport is the SPI master block.
interface spi_sample_master_if #(
  parameter int unsigned FRAME_BITS = 16
) ();

  logic                  tx_valid;
  logic                  tx_ready;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  rx_valid;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, busy
  );

endinterface

// File: rtl/spi_sample_master.sv
// SPI mode-0 master. It sends one FRAME_BITS frame, MSB first, for each accepted word.
// It captures miso on every sck rise and reports the received word with a one-cycle rx_valid pulse.
//   clk, reset : system clock; asynchronous active-high reset
//   host       : word handshake (tx_valid/tx_ready/tx_data, rx_valid/rx_data, busy)
//   sck        : SPI clock, idles low; CLK_DIV clk cycles per half-period
//   mosi       : serial out, changes only while sck is low
//   miso       : serial in, sampled on sck rise (slave shifts on sck fall)
//   cs_n       : frame select, low for (2*FRAME_BITS+1)*CLK_DIV cycles per frame
module spi_sample_master #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_sample_master_if.slave    host,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_TAIL = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  // One counter times both sck phases and the inter-frame gap.
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [2:0]            state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  // Bits still to send after the one currently on mosi.
  logic [FRAME_BITS-2:0] tx_rem, tx_rem_d;
  logic [FRAME_BITS-1:0] rx_sh, rx_sh_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sck_d, mosi_d, cs_n_d;

  assign host.tx_ready = (state == S_IDLE);
  assign host.busy     = (state != S_IDLE);
  assign host.rx_valid = rx_valid_q;
  assign host.rx_data  = rx_data_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_q      <= '0;
      tx_rem     <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_q      <= bit_d;
      tx_rem     <= tx_rem_d;
      rx_sh      <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sck        <= sck_d;
      mosi       <= mosi_d;
      cs_n       <= cs_n_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_d      = bit_q;
    tx_rem_d   = tx_rem;
    rx_sh_d    = rx_sh;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck;
    mosi_d     = mosi;
    cs_n_d     = cs_n;

    case (state)
      S_IDLE: begin
        if (host.tx_valid) begin
          tx_rem_d = host.tx_data[FRAME_BITS-2:0];
          mosi_d   = host.tx_data[FRAME_BITS-1];
          cs_n_d   = 1'b0;
          bit_d    = '0;
          cnt_d    = '0;
          state_d  = S_LEAD;
        end
      end

      // LEAD gives mosi one half-period of setup before the first rise.
      S_LEAD, S_LOW: begin
        if (cnt == DIV_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh[FRAME_BITS-2:0], miso};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (cnt == DIV_LAST) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = S_TAIL;
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            mosi_d   = tx_rem[FRAME_BITS-2];
            tx_rem_d = tx_rem << 1;
            state_d  = S_LOW;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      // TAIL holds cs_n low for the last sck-low half-period.
      S_TAIL: begin
        if (cnt == DIV_LAST) begin
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh;
          rx_valid_d = 1'b1;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_sample_master.sv
// Self-checking bench for spi_sample_master (CLK_DIV=2, FRAME_BITS=16, GAP_CYCLES=4).
// A negedge monitor measures every frame on the SPI pins, and a slave model drives miso.
// Each measured frame is compared with values derived from the frame rules.
module tb_spi_sample_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned FB      = 16;
  localparam int unsigned GAP     = 4;
  localparam int          LOW_LEN = (2 * FB + 1) * CLK_DIV;

  localparam int M_SLAVE = 0;
  localparam int M_LOOP  = 1;
  localparam int M_ONES  = 2;

  logic clk = 1'b0;
  logic reset;
  logic sck, mosi, miso, cs_n;

  spi_sample_master_if #(.FRAME_BITS(FB)) bus ();

  spi_sample_master #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FB),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .host (bus),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso),
    .cs_n (cs_n)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: miso comes from slave_word, loopback of mosi, or a constant 1.
  int          mode = M_SLAVE;
  logic [15:0] slave_word = 16'h0000;
  int          sl_idx = 0;
  logic        miso_s = 1'b0;

  always_comb begin
    miso = miso_s;
    if (mode == M_LOOP)      miso = mosi;
    else if (mode == M_ONES) miso = 1'b1;
  end

  // Monitor state and per-frame measurement queues.
  logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_rxv = 1'b0;
  int          low_cnt = 0, hi_cnt = 0, rises = 0, first_rise = -1;
  logic [15:0] mword = '0;
  bit          frame_done = 1'b0;
  int          outside_rises = 0, long_pulse = 0;
  int          mosi_q[$], len_q[$], first_q[$], rises_q[$], rx_q[$], coinc_q[$], gap_q[$];

  task automatic monitor_step();
    if (prev_cs && !cs_n) begin
      if (frame_done) gap_q.push_back(hi_cnt);
      low_cnt    = 0;
      rises      = 0;
      first_rise = -1;
      mword      = '0;
      sl_idx     = 0;
      miso_s     = slave_word[15];
    end
    if (!cs_n) begin
      if (sck && !prev_sck) begin
        if (rises == 0) first_rise = low_cnt;
        rises++;
        mword = {mword[14:0], mosi};
      end
      if (!sck && prev_sck) begin
        sl_idx++;
        miso_s = (sl_idx < 16) ? slave_word[15 - sl_idx] : 1'b0;
      end
      low_cnt++;
    end else begin
      if (sck && !prev_sck) outside_rises++;
      if (!prev_cs) begin
        mosi_q.push_back(int'(mword));
        len_q.push_back(low_cnt);
        first_q.push_back(first_rise);
        rises_q.push_back(rises);
        frame_done = 1'b1;
        hi_cnt     = 0;
      end
      hi_cnt++;
    end
    if (bus.rx_valid) begin
      rx_q.push_back(int'(bus.rx_data));
      coinc_q.push_back((!prev_cs && cs_n) ? 1 : 0);
      if (prev_rxv) long_pulse++;
    end
    prev_sck = sck;
    prev_cs  = cs_n;
    prev_rxv = bus.rx_valid;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic clear_queues();
    mosi_q.delete(); len_q.delete(); first_q.delete(); rises_q.delete();
    rx_q.delete(); coinc_q.delete(); gap_q.delete();
    frame_done = 1'b0;
  endtask

  // Presents a word and waits for it to be accepted; hold keeps tx_valid high.
  task automatic send(input logic [15:0] w, input bit hold);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    for (int i = 0; i < 400 && !bus.tx_ready; i++) @(negedge clk);
    check("accept_ready", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    if (!hold) bus.tx_valid = 1'b0;
    bus.tx_data = 16'($urandom);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 600 && rx_q.size() < n; i++) @(negedge clk);
    check("rx_arrived", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_tx, input logic [15:0] exp_rx);
    if (len_q.size() == 0 || rx_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_mosi"},  32'(mosi_q.pop_front()),  32'(exp_tx));
    check({tag, "_cslow"}, 32'(len_q.pop_front()),   32'(LOW_LEN));
    check({tag, "_first"}, 32'(first_q.pop_front()), 32'(CLK_DIV));
    check({tag, "_rises"}, 32'(rises_q.pop_front()), 32'(FB));
    check({tag, "_rx"},    32'(rx_q.pop_front()),    32'(exp_rx));
    check({tag, "_coinc"}, 32'(coinc_q.pop_front()), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w, s;
    logic [15:0] words[3];
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    // Reset values
    #12;
    check("rst_sck",      32'(sck),          32'd0);
    check("rst_cs_n",     32'(cs_n),         32'd1);
    check("rst_mosi",     32'(mosi),         32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data",  32'(bus.rx_data),  32'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed word, slave answers a random word
    mode       = M_SLAVE;
    slave_word = 16'($urandom);
    send(16'h03A5, 1'b0);
    wait_rx(1);
    check_frame("w03a5", 16'h03A5, slave_word);

    // Loopback
    mode = M_LOOP;
    send(16'h03A5, 1'b0);
    wait_rx(1);
    check_frame("loop", 16'h03A5, 16'h03A5);
    repeat (10) @(negedge clk);
    check("rx_hold", 32'(bus.rx_data), 32'h03A5);

    // Slave returns 5A5A, then miso tied high
    mode       = M_SLAVE;
    slave_word = 16'h5A5A;
    send(16'h0000, 1'b0);
    wait_rx(1);
    check_frame("slave5a5a", 16'h0000, 16'h5A5A);
    mode = M_ONES;
    w    = 16'($urandom);
    send(w, 1'b0);
    wait_rx(1);
    check_frame("ones", w, 16'hFFFF);

    // Random words against random slave answers
    mode = M_SLAVE;
    for (int k = 0; k < 4; k++) begin
      w          = 16'($urandom);
      s          = 16'($urandom);
      slave_word = s;
      send(w, 1'b0);
      wait_rx(1);
      check_frame("rand", w, s);
    end

    // Back-to-back with tx_valid held
    clear_queues();
    mode     = M_LOOP;
    words[0] = 16'h0001;
    words[1] = 16'h0002;
    words[2] = 16'h0003;
    for (int k = 0; k < 3; k++) send(words[k], (k < 2) ? 1'b1 : 1'b0);
    wait_rx(3);
    check("b2b_pulses", 32'(rx_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) check_frame("b2b", words[k], words[k]);
    check("b2b_gaps", 32'(gap_q.size()), 32'd2);
    while (gap_q.size() > 0) check("b2b_gap_len", 32'(gap_q.pop_front()), 32'(GAP + 1));

    // Reset after the fifth sck rise of a frame
    clear_queues();
    mode = M_SLAVE;
    send(16'h1234, 1'b0);
    for (int i = 0; i < 200 && rises < 5; i++) @(posedge clk);
    check("abort_reached_rise5", 32'(rises >= 5), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_sck",  32'(sck),          32'd0);
    check("abort_cs_n", 32'(cs_n),         32'd1);
    check("abort_busy", 32'(bus.busy),     32'd0);
    check("abort_rxv",  32'(bus.rx_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_no_rx", 32'(rx_q.size()), 32'd0);
    clear_queues();
    mode = M_LOOP;
    send(16'hBEEF, 1'b0);
    wait_rx(1);
    check_frame("beef", 16'hBEEF, 16'hBEEF);

    check("no_stray_rises", 32'(outside_rises), 32'd0);
    check("single_pulses",  32'(long_pulse),    32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
